seg_ctrl_mc: RTL

- Pipeline hazard/segment controller for the 5-stage core. Successor to the single-cycle load-use/branch controller.
- Generalised to N ID read ports and a parametrised load-use bubble count for multi-cycle data memory.
- Adds a data-memory wait freeze with a watchdog, and a multi-cycle mul/div busy stall.
- Sits beside the pipeline registers and drives all per-stage stall/flush controls.

---
 rtl/seg_ctrl_mc_if.sv | 42 ++++
 rtl/seg_ctrl_mc.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/seg_ctrl_mc_if.sv
// rtl/seg_ctrl_mc_if.sv - pipeline-side hazard inputs and per-stage stall/flush controls
// master = pipeline datapath, slave = seg_ctrl_mc.
interface seg_ctrl_mc_if #(
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) ();
  logic                     rf_we_ex;
  logic [1:0]               rf_wd_sel_ex;
  logic [ADDR_W-1:0]        rf_wa_ex;
  logic [NUM_RD*ADDR_W-1:0] rf_ra_id;
  logic [1:0]               npc_sel_ex;
  logic                     md_start_ex;
  logic                     md_done;
  logic                     dmem_req_mem;
  logic                     dmem_ready;
  logic                     stall_pc;
  logic                     stall_if_id;
  logic                     stall_id_ex;
  logic                     stall_ex_mem;
  logic                     flush_if_id;
  logic                     flush_id_ex;
  logic                     flush_ex_mem;
  logic                     flush_mem_wb;
  logic [1:0]               state_o;
  logic                     err_timeout;

  modport master (
    output rf_we_ex, rf_wd_sel_ex, rf_wa_ex, rf_ra_id, npc_sel_ex,
           md_start_ex, md_done, dmem_req_mem, dmem_ready,
    input  stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
           flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb,
           state_o, err_timeout
  );

  modport slave (
    input  rf_we_ex, rf_wd_sel_ex, rf_wa_ex, rf_ra_id, npc_sel_ex,
           md_start_ex, md_done, dmem_req_mem, dmem_ready,
    output stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
           flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb,
           state_o, err_timeout
  );
endinterface

// File: rtl/seg_ctrl_mc.sv
// rtl/seg_ctrl_mc.sv - 5-stage pipeline hazard/segment controller with multi-cycle load-use, mul/div and dmem freeze
// Priority: dmem wait freeze > mul/div busy > branch redirect > load-use.
module seg_ctrl_mc #(
  parameter int ADDR_W      = 5,
  parameter int NUM_RD      = 2,
  parameter int LU_BUBBLES  = 1,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  seg_ctrl_mc_if.slave bus
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LU   = 2'd1;
  localparam logic [1:0] ST_MD   = 2'd2;
  localparam logic [1:0] ST_MW   = 2'd3;

  logic [1:0]       state;
  logic [1:0]       saved_state;
  logic [1:0]       eff_state;
  logic [1:0]       nxt_state;
  logic [2:0]       lu_cnt;
  logic [2:0]       nxt_lu;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_inc;
  logic             err_q;

  logic rd_hit;
  logic loaduse;
  logic br;
  logic mwait;

  logic s_pc, s_ifid, s_idex, s_exmem;
  logic f_ifid, f_idex, f_exmem, f_memwb;

  always_comb begin
    rd_hit = 1'b0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (bus.rf_ra_id[k*ADDR_W +: ADDR_W] == bus.rf_wa_ex) rd_hit = 1'b1;
    end
  end

  assign loaduse = (bus.rf_wd_sel_ex == 2'b10) && bus.rf_we_ex &&
                   (bus.rf_wa_ex != '0) && rd_hit;
  assign br      = (bus.npc_sel_ex == 2'b01) || (bus.npc_sel_ex == 2'b10);
  assign mwait   = bus.dmem_req_mem && !bus.dmem_ready;

  // After a freeze the register still reads MEM_WAIT; behave as the saved state.
  assign eff_state = (state == ST_MW) ? saved_state : state;
  assign wait_inc  = (&wait_cnt) ? wait_cnt : wait_cnt + 1'b1;

  always_comb begin
    s_pc      = 1'b0;
    s_ifid    = 1'b0;
    s_idex    = 1'b0;
    s_exmem   = 1'b0;
    f_ifid    = 1'b0;
    f_idex    = 1'b0;
    f_exmem   = 1'b0;
    f_memwb   = 1'b0;
    nxt_state = eff_state;
    nxt_lu    = lu_cnt;
    if (mwait) begin
      s_pc    = 1'b1;
      s_ifid  = 1'b1;
      s_idex  = 1'b1;
      s_exmem = 1'b1;
      f_memwb = 1'b1;
    end else begin
      case (eff_state)
        ST_IDLE: begin
          if (br) begin
            f_ifid = 1'b1;
            f_idex = 1'b1;
          end else if (loaduse && !bus.md_start_ex) begin
            s_pc   = 1'b1;
            s_ifid = 1'b1;
            f_idex = 1'b1;
          end
          if (bus.md_start_ex) begin
            nxt_state = ST_MD;
          end else if (!br && loaduse && (LU_BUBBLES > 1)) begin
            nxt_state = ST_LU;
            nxt_lu    = 3'(LU_BUBBLES - 1);
          end
        end
        ST_LU: begin
          s_pc   = 1'b1;
          s_ifid = 1'b1;
          f_idex = 1'b1;
          nxt_lu = lu_cnt - 3'd1;
          if (lu_cnt <= 3'd1) nxt_state = ST_IDLE;
        end
        ST_MD: begin
          if (bus.md_done) begin
            nxt_state = ST_IDLE;
          end else begin
            s_pc    = 1'b1;
            s_ifid  = 1'b1;
            s_idex  = 1'b1;
            f_exmem = 1'b1;
          end
        end
        default: nxt_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      saved_state <= ST_IDLE;
      lu_cnt      <= 3'd0;
      wait_cnt    <= '0;
      err_q       <= 1'b0;
    end else if (mwait) begin
      if (state != ST_MW) saved_state <= state;
      state    <= ST_MW;
      wait_cnt <= wait_inc;
      if (wait_inc >= CNT_W'(MEM_TIMEOUT)) err_q <= 1'b1;
    end else begin
      state    <= nxt_state;
      lu_cnt   <= nxt_lu;
      wait_cnt <= '0;
    end
  end

  // Gating with rst_n keeps the freeze outputs low while reset is held.
  assign bus.stall_pc     = rst_n & s_pc;
  assign bus.stall_if_id  = rst_n & s_ifid;
  assign bus.stall_id_ex  = rst_n & s_idex;
  assign bus.stall_ex_mem = rst_n & s_exmem;
  assign bus.flush_if_id  = rst_n & f_ifid;
  assign bus.flush_id_ex  = rst_n & f_idex;
  assign bus.flush_ex_mem = rst_n & f_exmem;
  assign bus.flush_mem_wb = rst_n & f_memwb;
  assign bus.state_o      = (rst_n && mwait) ? ST_MW : eff_state;
  assign bus.err_timeout  = err_q;
endmodule
